// File: rtl/iomem_cmd_master.sv
// iomem_cmd_master: host byte-stream initiator on the PicoSoC iomem bus.
// Parses 'W'/'R' commands, runs one bus transfer per command, streams back K/T/? responses.
module iomem_cmd_master #(
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        iomem_valid,
  input  logic        iomem_ready,
  output logic [3:0]  iomem_wstrb,
  output logic [31:0] iomem_addr,
  output logic [31:0] iomem_wdata,
  input  logic [31:0] iomem_rdata,
  output logic        busy
);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TLAST = TW'(TIMEOUT_CYCLES - 1);
  typedef enum logic [2:0] {IDLE, ADDR, STRB, DATA, BUS, RESP} state_t;
  state_t        r_state;
  logic [1:0]    r_cnt;
  logic          r_wr;
  logic [TW-1:0] r_tmo;
  logic [31:0]   r_resp;
  logic [2:0]    r_left;
  logic          w_rx;
  assign w_rx = rx_valid && rx_ready;
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_wr        <= 1'b0;
      r_tmo       <= '0;
      r_resp      <= '0;
      r_left      <= '0;
      rx_ready    <= 1'b0;
      tx_data     <= '0;
      tx_valid    <= 1'b0;
      iomem_valid <= 1'b0;
      iomem_wstrb <= '0;
      iomem_addr  <= '0;
      iomem_wdata <= '0;
      busy        <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          rx_ready <= 1'b1;
          if (w_rx) begin
            busy  <= 1'b1;
            r_cnt <= '0;
            r_wr  <= rx_data == 8'h57;
            if (rx_data == 8'h57 || rx_data == 8'h52) begin
              r_state <= ADDR;
            end else begin
              rx_ready <= 1'b0;
              tx_data  <= 8'h3F;
              tx_valid <= 1'b1;
              r_left   <= '0;
              r_state  <= RESP;
            end
          end
        end
        ADDR: if (w_rx) begin
          iomem_addr <= {iomem_addr[23:0], rx_data};
          r_cnt      <= r_cnt + 2'd1;
          if (r_cnt == 2'd3) begin
            if (r_wr) begin
              r_state <= STRB;
            end else begin
              iomem_wstrb <= '0;
              rx_ready    <= 1'b0;
              iomem_valid <= 1'b1;
              r_tmo       <= '0;
              r_state     <= BUS;
            end
          end
        end
        STRB: if (w_rx) begin
          iomem_wstrb <= rx_data[3:0];
          if (|rx_data[3:0]) begin
            r_state <= DATA;
          end else begin
            rx_ready <= 1'b0;
            tx_data  <= 8'h3F;
            tx_valid <= 1'b1;
            r_left   <= '0;
            r_state  <= RESP;
          end
        end
        DATA: if (w_rx) begin
          iomem_wdata <= {iomem_wdata[23:0], rx_data};
          r_cnt       <= r_cnt + 2'd1;
          if (r_cnt == 2'd3) begin
            rx_ready    <= 1'b0;
            iomem_valid <= 1'b1;
            r_tmo       <= '0;
            r_state     <= BUS;
          end
        end
        BUS: begin
          // ready takes priority over a timeout expiring in the same cycle
          if (iomem_ready) begin
            iomem_valid <= 1'b0;
            r_resp      <= iomem_rdata;
            tx_data     <= 8'h4B;
            tx_valid    <= 1'b1;
            r_left      <= r_wr ? 3'd0 : 3'd4;
            r_state     <= RESP;
          end else if (r_tmo == TLAST) begin
            iomem_valid <= 1'b0;
            tx_data     <= 8'h54;
            tx_valid    <= 1'b1;
            r_left      <= '0;
            r_state     <= RESP;
          end else begin
            r_tmo <= r_tmo + 1'b1;
          end
        end
        RESP: if (tx_ready) begin
          if (r_left == 3'd0) begin
            tx_valid <= 1'b0;
            busy     <= 1'b0;
            rx_ready <= 1'b1;
            r_state  <= IDLE;
          end else begin
            tx_data <= r_resp[31:24];
            r_resp  <= {r_resp[23:0], 8'h00};
            r_left  <= r_left - 3'd1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_iomem_cmd_master.sv
// tb_iomem_cmd_master: scoreboard bench for iomem_cmd_master with a behavioural bus responder.
module tb_iomem_cmd_master;
  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic [7:0]  rx_data = '0;
  logic        rx_valid = 1'b0;
  logic        rx_ready;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready = 1'b0;
  logic        iomem_valid;
  logic        iomem_ready = 1'b0;
  logic [3:0]  iomem_wstrb;
  logic [31:0] iomem_addr;
  logic [31:0] iomem_wdata;
  logic [31:0] iomem_rdata = '0;
  logic        busy;
  int checks = 0;
  int errors = 0;
  logic [7:0]  txq[$];
  logic [68:0] busq[$];
  int          tx_bp = 0;
  int          bus_wait = 0;
  int          vlen = 0;
  logic [31:0] resp_data = '0;
  iomem_cmd_master #(.TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .resetn(resetn),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .iomem_valid(iomem_valid), .iomem_ready(iomem_ready), .iomem_wstrb(iomem_wstrb),
    .iomem_addr(iomem_addr), .iomem_wdata(iomem_wdata), .iomem_rdata(iomem_rdata),
    .busy(busy)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  int          hold = 0;
  logic        held = 1'b0;
  logic [7:0]  held_d = '0;
  always @(negedge clk) begin
    if (!resetn) begin
      tx_ready = 1'b0;
      hold = 0;
      held = 1'b0;
    end else begin
      if (held) begin
        chk("tx_hold_valid", tx_valid, 1);
        chk("tx_hold_data", tx_data, held_d);
      end
      held = 1'b0;
      tx_ready = tx_valid && hold >= tx_bp;
      if (tx_valid && tx_ready) begin
        if (txq.size() == 0) chk("tx_extra_byte", txq.size(), 1);
        else chk("tx_byte", tx_data, txq.pop_front());
        hold = 0;
      end else if (tx_valid) begin
        hold++;
        held = 1'b1;
        held_d = tx_data;
      end
    end
  end
  int          vcnt = 0;
  logic        done_prev = 1'b0;
  logic [68:0] cur = '0;
  logic [67:0] snap = '0;
  always @(negedge clk) begin
    if (!resetn) begin
      iomem_ready = 1'b0;
      vcnt = 0;
      done_prev = 1'b0;
    end else begin
      if (done_prev) chk("valid_drop", iomem_valid, 0);
      done_prev = 1'b0;
      if (iomem_valid) begin
        vcnt++;
        if (vcnt == 1) begin
          snap = {iomem_addr, iomem_wstrb, iomem_wdata};
          if (busq.size() == 0) chk("bus_extra_cycle", busq.size(), 1);
          else begin
            cur = busq.pop_front();
            chk("bus_addr", iomem_addr, cur[67:36]);
            chk("bus_wstrb", iomem_wstrb, cur[35:32]);
            if (!cur[68]) chk("bus_wdata", iomem_wdata, cur[31:0]);
          end
        end else begin
          chk("bus_stable", {iomem_addr, iomem_wstrb, iomem_wdata}, snap);
        end
        iomem_ready = bus_wait >= 0 && vcnt == bus_wait + 1;
        iomem_rdata = iomem_ready ? resp_data : $urandom;
        done_prev = iomem_ready;
        vlen = vcnt;
      end else begin
        iomem_ready = 1'b0;
        vcnt = 0;
      end
    end
  end
  task automatic send(input logic [7:0] b, input int gap);
    int n = 0;
    repeat (gap) @(negedge clk);
    rx_data = b;
    rx_valid = 1'b1;
    while (!rx_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) chk("rx_accept_timeout", n, 0);
    @(negedge clk);
    rx_valid = 1'b0;
  endtask
  task automatic cmd_write(input logic [31:0] a, input logic [7:0] s, input logic [31:0] d, input int gap);
    if (s[3:0] != 4'h0) begin
      busq.push_back({1'b0, a, s[3:0], d});
      txq.push_back(8'h4B);
    end else begin
      txq.push_back(8'h3F);
    end
    send(8'h57, gap);
    for (int i = 3; i >= 0; i--) send(a[i*8 +: 8], gap);
    send(s, gap);
    if (s[3:0] != 4'h0) for (int i = 3; i >= 0; i--) send(d[i*8 +: 8], gap);
  endtask
  task automatic cmd_read(input logic [31:0] a, input int gap, input bit to);
    busq.push_back({1'b1, a, 4'h0, 32'h0});
    if (to) txq.push_back(8'h54);
    else begin
      txq.push_back(8'h4B);
      for (int i = 3; i >= 0; i--) txq.push_back(resp_data[i*8 +: 8]);
    end
    send(8'h52, gap);
    for (int i = 3; i >= 0; i--) send(a[i*8 +: 8], gap);
  endtask
  task automatic wait_done(input string tag);
    int n = 0;
    while ((txq.size() != 0 || busy) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    chk(tag, n < 3000, 1);
    chk("bus_pending", busq.size(), 0);
  endtask
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end
  initial begin
    repeat (3) @(negedge clk);
    chk("rst_rx_ready", rx_ready, 0);
    chk("rst_tx_valid", tx_valid, 0);
    chk("rst_tx_data", tx_data, 0);
    chk("rst_iomem_valid", iomem_valid, 0);
    chk("rst_wstrb", iomem_wstrb, 0);
    chk("rst_addr", iomem_addr, 0);
    chk("rst_wdata", iomem_wdata, 0);
    chk("rst_busy", busy, 0);
    resetn = 1'b1;
    @(negedge clk);
    bus_wait = 1;
    cmd_write(32'h0300_0000, 8'h0F, 32'h0000_00A5, 0);
    wait_done("write_led_done");
    chk("write_vlen", vlen, 2);
    bus_wait = 3;
    resp_data = 32'hDEAD_BEEF;
    cmd_read(32'h0300_0000, 0, 1'b0);
    wait_done("read_done");
    chk("read_vlen", vlen, 4);
    bus_wait = -1;
    cmd_read(32'h0200_0000, 0, 1'b1);
    wait_done("timeout_done");
    chk("timeout_vlen", vlen, 16);
    bus_wait = 0;
    resp_data = 32'h1234_5678;
    cmd_read(32'h0200_0004, 0, 1'b0);
    wait_done("after_timeout_done");
    txq.push_back(8'h3F);
    send(8'h41, 0);
    wait_done("bad_cmd_done");
    cmd_write(32'h0300_0010, 8'hF0, 32'h0, 0);
    wait_done("zero_strb_done");
    tx_bp = 5;
    bus_wait = 2;
    resp_data = 32'hCAFE_F00D;
    cmd_read(32'h0300_0020, 2, 1'b0);
    wait_done("bp_read_done");
    cmd_write(32'h0300_0024, 8'h93, 32'h8765_4321, 3);
    wait_done("gap_write_done");
    tx_bp = 0;
    bus_wait = -1;
    cmd_read(32'h0200_0100, 0, 1'b1);
    repeat (3) @(negedge clk);
    chk("pre_reset_valid", iomem_valid, 1);
    resetn = 1'b0;
    @(negedge clk);
    chk("mid_reset_valid", iomem_valid, 0);
    chk("mid_reset_busy", busy, 0);
    chk("mid_reset_tx_valid", tx_valid, 0);
    txq.delete();
    busq.delete();
    resetn = 1'b1;
    @(negedge clk);
    bus_wait = 1;
    cmd_write(32'h0300_0000, 8'h0F, 32'h0000_005A, 1);
    wait_done("post_reset_write_done");
    bus_wait = 15;
    resp_data = 32'h0BAD_F00D;
    cmd_read(32'h0200_0008, 0, 1'b0);
    wait_done("race_done");
    chk("race_vlen", vlen, 16);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/iomem_cmd_master.md
Name: iomem_cmd_master

Overview:
- Byte-stream-driven initiator on the PicoSoC iomem bus.
- Parses host command bytes (delivered by a UART receiver), issues one iomem read or write per command, and returns response bytes to a UART transmitter.
- Allows a host PC to peek/poke iomem peripherals (e.g. the GPIO/LED register at 0x03xx_xxxx) without CPU involvement.
- Sits beside the CPU on the iomem bus, behind the arbiter.

Parameters:
- TIMEOUT_CYCLES, 1024: cycles iomem_valid may stay high without iomem_ready before the transfer is abandoned; must be ≥ 2.

Ports:
- clk  in  1  system clock
- resetn  in  1  synchronous, active-low reset
- rx_data  in  8  command byte from UART receiver
- rx_valid  in  1  rx_data valid
- rx_ready  out  1  block accepts rx_data this cycle
- tx_data  out  8  response byte to UART transmitter
- tx_valid  out  1  tx_data valid
- tx_ready  in  1  transmitter accepts tx_data this cycle
- iomem_valid  out  1  bus request
- iomem_ready  in  1  responder completion
- iomem_wstrb  out  4  byte write strobes; 0 = read
- iomem_addr  out  32  bus address
- iomem_wdata  out  32  write data
- iomem_rdata  in  32  read data, valid when iomem_ready=1
- busy  out  1  high in any state except IDLE

Behaviour:
- Clock and reset: clk, resetn, synchronous, active-low.
- Reset values (all outputs): rx_ready=0, tx_valid=0, tx_data=0, iomem_valid=0, iomem_wstrb=0, iomem_addr=0, iomem_wdata=0, busy=0.
- Reset asserted mid-operation drops iomem_valid and tx_valid the next edge and discards partially received commands.
- Byte transfer occurs on any cycle with rx_valid && rx_ready (same rule for tx).

Command format:
- Write: 0x57 'W', then ADDR[31:24], [23:16], [15:8], [7:0], then STRB byte (bits 3:0 used, 7:4 ignored), then DATA MSB first (4 bytes).
- Read: 0x52 'R', then 4 ADDR bytes MSB first.

States:
- IDLE: rx_ready=1.
  - 'W'/'R' → ADDR with byte counter=0.
  - Any other byte → RESP, queue single byte 0x3F '?'.
- ADDR: rx_ready=1. Shift bytes into addr. After the 4th byte → STRB (write) or BUS (read, wstrb=0).
- STRB: rx_ready=1.
  - Nibble ≠ 0 → DATA.
  - Nibble = 0 → RESP with '?', no bus cycle.
- DATA: rx_ready=1. Shift 4 bytes into wdata. After the 4th → BUS.
- BUS:
  - rx_ready=0. iomem_valid=1 from the cycle after the last command byte is accepted. addr/wdata/wstrb held stable while valid.
  - On iomem_ready=1 (sampled only while valid): capture iomem_rdata; valid=0 next cycle; → RESP with 'K' (0x4B), plus 4 rdata bytes MSB first if read.
  - Timeout counter increments each valid cycle. After TIMEOUT_CYCLES cycles without ready: valid=0, → RESP with 'T' (0x54) only.
  - iomem_ready on the same cycle the counter expires: ready wins (success).
- RESP:
  - rx_ready=0. tx_valid=1 with tx_data stable until tx_ready.
  - Next queued byte presented the cycle after acceptance; tx_valid may stay high between bytes.
  - After the last byte: tx_valid=0, → IDLE.
- Back-to-back rule: one bus transaction per command; at least one cycle with iomem_valid=0 between transactions.
- Counters: byte counter is 2 bits and wraps by state exit only. Timeout counter is $clog2(TIMEOUT_CYCLES+1) bits and cleared on BUS entry.

Test Plan:
- Write to LED register: rx 57 03 00 00 00 0F 00 00 00 A5 → one iomem cycle with addr=0x03000000, wstrb=0xF, wdata=0x000000A5; valid held until ready (responder ready after 1 cycle); tx 4B.
- Read: rx 52 03 00 00 00, responder returns 0xDEADBEEF after 3 wait cycles → wstrb=0 throughout, tx 4B DE AD BE EF in order; valid drops the cycle after ready.
- Timeout: TIMEOUT_CYCLES=16, rx read to 0x02000000, responder never ready → valid high exactly 16 cycles, then tx 54; next command accepted normally.
- Error paths:
  - Bad command byte 0x41 → tx 3F, no iomem_valid.
  - 'W' with STRB=0xF0 → tx 3F after the STRB byte, no bus cycle.
- Backpressure and holds: tx_ready low 5 cycles per byte during a read response, and rx_valid gaps between command bytes → identical bytes and order, tx_data stable while held, addr/wdata stable while valid.
- Reset and race: resetn low while in BUS → valid=0, busy=0 after the edge; a fresh write then completes. Separately, ready coincident with timeout expiry → tx 4B, not 54.
